// File: rtl/aes_enc_arbiter.sv
// Round-robin arbiter that shares one AES encryption engine between NREQ requesters,
// sequencing one cs/done job at a time and aborting jobs whose done never arrives.
module aes_enc_arbiter #(
  parameter int NREQ    = 2,
  parameter int TIMEOUT = 1024,
  parameter int TW      = 16
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_ni,
  input  logic [NREQ-1:0]      req_i,
  input  logic [NREQ*128-1:0]  req_pt_i,
  output logic [NREQ-1:0]      ack_o,
  output logic [NREQ-1:0]      done_o,
  output logic [127:0]         ct_o,
  output logic                 err_o,
  output logic                 busy_o,
  output logic                 enc_cs,
  output logic [127:0]         plaintext_o,
  input  logic                 enc_done,
  input  logic [127:0]         ciphertext_i
);

  localparam int LW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [TW-1:0] WD_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
  localparam bit WD_EN = (TIMEOUT != 0);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t          state_r;
  logic [LW-1:0]   last_r;
  logic [LW-1:0]   cur_r;
  logic [TW-1:0]   wd_r;
  logic [NREQ-1:0] ack_r;
  logic [NREQ-1:0] done_r;
  logic [127:0]    ct_r;
  logic [127:0]    pt_r;
  logic            err_r;
  logic            busy_r;
  logic            enc_cs_r;

  logic [LW-1:0]   grant_idx_s;
  logic            grant_found_s;
  logic            wd_expire_s;

  function automatic logic [NREQ-1:0] to_onehot(input logic [LW-1:0] idx);
    to_onehot = {{(NREQ-1){1'b0}}, 1'b1} << idx;
  endfunction

  // Round-robin pick: first requester after the last one served, wrapping around.
  always_comb begin
    grant_found_s = 1'b0;
    grant_idx_s   = {LW{1'b0}};
    for (int i = 1; i <= NREQ; i++) begin
      int idx;
      idx = (int'(last_r) + i) % NREQ;
      grant_idx_s   = (!grant_found_s && req_i[LW'(idx)]) ? LW'(idx) : grant_idx_s;
      grant_found_s = grant_found_s | req_i[LW'(idx)];
    end
  end

  // Watchdog expiry; a simultaneous enc_done takes precedence in the FSM.
  always_comb begin
    wd_expire_s = WD_EN && (wd_r == WD_LAST);
  end

  // Job sequencer: IDLE grants and launches, BUSY waits for done or the watchdog.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_r  <= ST_IDLE;
      last_r   <= LW'(NREQ - 1);
      cur_r    <= {LW{1'b0}};
      wd_r     <= {TW{1'b0}};
      ack_r    <= {NREQ{1'b0}};
      done_r   <= {NREQ{1'b0}};
      ct_r     <= 128'h0;
      pt_r     <= 128'h0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
      enc_cs_r <= 1'b0;
    end else begin
      ack_r    <= {NREQ{1'b0}};
      done_r   <= {NREQ{1'b0}};
      err_r    <= 1'b0;
      enc_cs_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_found_s) begin
            pt_r     <= req_pt_i[{grant_idx_s, 7'd0} +: 128];
            ack_r    <= to_onehot(grant_idx_s);
            enc_cs_r <= 1'b1;
            busy_r   <= 1'b1;
            cur_r    <= grant_idx_s;
            wd_r     <= {TW{1'b0}};
            state_r  <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          wd_r <= wd_r + TW'(1);
          if (enc_done) begin
            ct_r    <= ciphertext_i;
            done_r  <= to_onehot(cur_r);
            busy_r  <= 1'b0;
            last_r  <= cur_r;
            state_r <= ST_IDLE;
          end else if (wd_expire_s) begin
            done_r  <= to_onehot(cur_r);
            err_r   <= 1'b1;
            busy_r  <= 1'b0;
            last_r  <= cur_r;
            state_r <= ST_IDLE;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign ack_o       = ack_r;
  assign done_o      = done_r;
  assign ct_o        = ct_r;
  assign err_o       = err_r;
  assign busy_o      = busy_r;
  assign enc_cs      = enc_cs_r;
  assign plaintext_o = pt_r;

endmodule

// File: tb/tb_aes_enc_arbiter.sv
// Self-checking bench: job-level reference model (round-robin pick, latency rules)
// against a watchdog-enabled instance and a watchdog-disabled instance.
module tb_aes_enc_arbiter;
  localparam int NREQ    = 2;
  localparam int TIMEOUT = 16;
  localparam int TW      = 16;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [NREQ-1:0]     req, ack, done;
  logic [NREQ*128-1:0] req_pt;
  logic [127:0]        ct, pt_o, cipher;
  logic                err, busy, cs, enc_done;

  logic [NREQ-1:0]     req_z, ack_z, done_z;
  logic [NREQ*128-1:0] req_pt_z;
  logic [127:0]        ct_z, pt_o_z, cipher_z;
  logic                err_z, busy_z, cs_z, enc_done_z;

  aes_enc_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT), .TW(TW)) dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .req_i(req), .req_pt_i(req_pt),
    .ack_o(ack), .done_o(done), .ct_o(ct), .err_o(err), .busy_o(busy),
    .enc_cs(cs), .plaintext_o(pt_o), .enc_done(enc_done), .ciphertext_i(cipher)
  );

  aes_enc_arbiter #(.NREQ(NREQ), .TIMEOUT(0), .TW(TW)) dut_nowd (
    .wb_clk_i(clk), .wb_rst_ni(rst_n), .req_i(req_z), .req_pt_i(req_pt_z),
    .ack_o(ack_z), .done_o(done_z), .ct_o(ct_z), .err_o(err_z), .busy_o(busy_z),
    .enc_cs(cs_z), .plaintext_o(pt_o_z), .enc_done(enc_done_z), .ciphertext_i(cipher_z)
  );

  int tests = 0;
  int fails = 0;
  int m_last;
  logic [127:0] m_ct;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [NREQ-1:0] r);
    for (int i = 1; i <= NREQ; i++) begin
      int idx;
      idx = (m_last + i) % NREQ;
      if (r[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One job: request, expect ack next cycle, engine answers after d cycles (d<0: never).
  task automatic run_job(input logic [NREQ-1:0] r, input int d, input logic [127:0] c);
    int g, e, bad;
    logic experr;
    logic [127:0] exp_pt;
    g      = pick(r);
    exp_pt = req_pt[g*128 +: 128];
    req    = r;
    @(negedge clk);
    check_eq("ack", 128'(ack), 128'(2'b01 << g));
    check_eq("enc_cs", 128'({cs, busy}), 128'(2'b11));
    check_eq("plaintext", pt_o, exp_pt);
    experr = !(d >= 0 && d <= TIMEOUT - 1);
    e      = experr ? TIMEOUT : d + 1;
    bad    = 0;
    for (int k = 0; k < e; k++) begin
      if (k > 0 && (ack != 2'b00 || cs || done != 2'b00 || err || !busy || pt_o !== exp_pt)) bad++;
      enc_done = (k == d);
      cipher   = c;
      @(negedge clk);
    end
    enc_done = 1'b0;
    if (!experr) m_ct = c;
    check_eq("busy_quiet", 128'(bad), 128'(0));
    check_eq("done", 128'(done), 128'(2'b01 << g));
    check_eq("err", 128'({err, busy}), 128'({experr, 1'b0}));
    check_eq("ct", ct, m_ct);
    m_last = g;
    req    = 2'b00;
  endtask

  initial begin
    int bad;
    logic [NREQ-1:0] r;
    rst_n = 1'b0; req = 2'b00; req_pt = '0; enc_done = 1'b0; cipher = 128'h0;
    req_z = 2'b00; req_pt_z = '0; enc_done_z = 1'b0; cipher_z = 128'h0;
    m_last = NREQ - 1; m_ct = 128'h0;
    repeat (2) @(negedge clk);
    check_eq("rst_ctl", 128'({ack, done, cs, err, busy}), 128'(0));
    check_eq("rst_data", ct | pt_o, 128'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Known-answer single request
    req_pt[127:0] = 128'h00112233_44556677_8899aabb_ccddeeff;
    req_pt[255:128] = rnd128();
    run_job(2'b01, 12, 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a);

    // Contention: both held, grants must alternate
    for (int j = 0; j < 4; j++) run_job(2'b11, $urandom_range(0, 10), rnd128());

    // Watchdog abort, then race with expiry, then normal service
    run_job(2'b10, -1, rnd128());
    run_job(2'b01, TIMEOUT - 1, rnd128());
    run_job(2'b11, TIMEOUT, rnd128());
    run_job(2'b11, 0, rnd128());

    // Stray enc_done in IDLE
    cipher = rnd128(); enc_done = 1'b1;
    @(negedge clk);
    enc_done = 1'b0;
    @(negedge clk);
    check_eq("stray", 128'({done, err, busy}), 128'(0));
    check_eq("stray_ct", ct, m_ct);

    // Randomized jobs
    for (int j = 0; j < 30; j++) begin
      req_pt = {rnd128(), rnd128()};
      r = 2'($urandom_range(1, 3));
      run_job(r, ($urandom_range(0, 7) == 0) ? -1 : $urandom_range(0, 20), rnd128());
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end

    // Reset mid-job
    req = 2'b11;
    @(negedge clk);
    check_eq("rst_job_ack", 128'(ack), 128'(2'b01 << pick(2'b11)));
    req = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_ctl", 128'({ack, done, cs, err, busy}), 128'(0));
    check_eq("async_rst_data", ct | pt_o, 128'h0);
    @(negedge clk);
    rst_n = 1'b1;
    m_last = NREQ - 1; m_ct = 128'h0;
    cipher = rnd128(); enc_done = 1'b1;
    @(negedge clk);
    enc_done = 1'b0;
    @(negedge clk);
    check_eq("post_rst_stray", 128'({done, err, busy}), 128'(0));
    check_eq("post_rst_ct", ct, 128'h0);
    run_job(2'b11, 5, rnd128());

    // Watchdog disabled: very late completion is still normal
    req_pt_z = {rnd128(), rnd128()};
    cipher_z = rnd128();
    req_z = 2'b10;
    @(negedge clk);
    check_eq("nowd_ack", 128'({ack_z, cs_z}), 128'(3'b101));
    check_eq("nowd_pt", pt_o_z, req_pt_z[255:128]);
    req_z = 2'b00;
    bad = 0;
    for (int k = 0; k <= 5000; k++) begin
      if (k > 0 && (done_z != 2'b00 || err_z || !busy_z)) bad++;
      enc_done_z = (k == 5000);
      @(negedge clk);
    end
    enc_done_z = 1'b0;
    check_eq("nowd_quiet", 128'(bad), 128'(0));
    check_eq("nowd_done", 128'({done_z, err_z, busy_z}), 128'(4'b1000));
    check_eq("nowd_ct", ct_z, cipher_z);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
